// File: rtl/pipeline_if_pcgen_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_if_pcgen_pkg
//   Shared definitions for the instruction-fetch PC generator:
//     - default exception/interrupt/reset vectors
//     - 2-bit branch counter encodings and saturating update helper
//     - next-PC select enum and the helper that says which selects flush IF/ID
// ---------------------------------------------------------------------------
package pipeline_if_pcgen_pkg;

    // Default vector addresses (overridable through top-level parameters).
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEFAULT   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h8000_0008;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Next-PC source, listed in priority order (highest first).
    typedef enum logic [3:0] {
        SEL_IRQ     = 4'd0,
        SEL_EXC     = 4'd1,
        SEL_STALL   = 4'd2,
        SEL_MISPRED = 4'd3,
        SEL_JUMP    = 4'd4,
        SEL_ERET    = 4'd5,
        SEL_JR      = 4'd6,
        SEL_PRED    = 4'd7,
        SEL_SEQ     = 4'd8
    } npc_sel_e;

    // Saturating counter step: up on taken, down on not taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                res = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                res = ctr - 2'd1;
            end
        end
        return res;
    endfunction

    // Selects that are neither sequential, predicted nor a hold: the
    // instruction already fetched down the wrong path must be flushed.
    function automatic logic sel_is_redirect(input npc_sel_e sel);
        logic res;
        case (sel)
            SEL_IRQ, SEL_EXC, SEL_MISPRED,
            SEL_JUMP, SEL_ERET, SEL_JR:      res = 1'b1;
            default:                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipeline_if_pcgen_btb.sv
// ---------------------------------------------------------------------------
// pipeline_btb
//   Direct-mapped branch target buffer with a 2-bit saturating counter per
//   entry.
//
//   Ports:
//     clk, reset        clock (rising edge), async active-high reset
//     lookup_pc         fetch PC to predict for
//     pred_taken        hit and counter predicts taken
//     pred_target       stored target on hit, 0 on miss
//     upd_en            apply a resolved branch this edge
//     upd_pc            address of the resolved branch
//     upd_taken         actual outcome
//     upd_target        computed branch target
//
//   Lookup is purely combinational on the storage registers, so a lookup
//   and an update to the same index in one cycle see the old contents; the
//   write lands on the clock edge.
// ---------------------------------------------------------------------------
module pipeline_btb
    import pipeline_if_pcgen_pkg::*;
#(
    parameter int BTB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = 32 - IDX - 2;

    // Entry storage.
    logic             valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
    logic [31:0]      target_q [BTB_DEPTH];
    logic [1:0]       ctr_q    [BTB_DEPTH];

    // Instructions are word aligned; the byte offset never reaches the table.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // ---------------- lookup ----------------
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[31:IDX+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'h0;
        if (lk_hit) begin
            pred_taken  = ctr_q[lk_idx][1];
            pred_target = target_q[lk_idx];
        end
    end

    // ---------------- update ----------------
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[31:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pipeline_if_pcgen.sv
// ---------------------------------------------------------------------------
// pipeline_if_pcgen
//   Instruction-fetch PC generator for the 5-stage MIPS pipeline. Holds the
//   fetch PC, picks the next PC by fixed priority and predicts taken
//   branches through a BTB; predictions are resolved in ID.
//
//   Ports:
//     clk, reset                 clock (rising edge), async active-high reset
//     stall                      load-use hold
//     irq, exc                   interrupt / exception request
//     br_valid .. br_pred_target resolved conditional branch from ID,
//                                with the prediction it was fetched under
//     j_valid, j_index           J/JAL in ID
//     jr_valid, jr_target        JR/JALR in ID (forwarded rs)
//     eret_valid, eret_pc        exception return and saved EPC
//     pc, pc_plus4               fetch PC and its sequential successor
//     pred_taken, pred_target    BTB prediction for pc
//     redirect                   IF/ID must be flushed this cycle
//
//   Control semantics: every *_valid input is a single-cycle qualifier
//   sampled on the rising edge; there is no ready. A branch held in ID
//   under stall is re-presented each cycle, so it only trains the BTB on an
//   edge where the PC actually moves (any select except the hold).
// ---------------------------------------------------------------------------
module pipeline_if_pcgen
    import pipeline_if_pcgen_pkg::*;
#(
    parameter int          BTB_DEPTH = 16,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
    parameter int          KBIT      = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq,
    input  logic        exc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        br_pred_taken,
    input  logic [31:0] br_pred_target,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        eret_valid,
    input  logic [31:0] eret_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        redirect
);

    npc_sel_e    sel;
    logic [31:0] pc_next;
    logic        mispredict;
    logic [31:0] br_correct_pc;
    logic [31:0] jump_pc;
    logic [31:0] eret_clr_pc;
    logic        btb_upd_en;

    assign pc_plus4 = pc + 32'd4;

    // A branch mispredicts if the direction was wrong, or if it was
    // correctly predicted taken but towards a stale target.
    assign mispredict = br_valid &&
                        ((br_taken != br_pred_taken) ||
                         (br_taken && br_pred_taken && (br_target != br_pred_target)));

    assign br_correct_pc = br_taken ? br_target : (br_pc + 32'd4);
    assign jump_pc       = {pc[31:28], j_index, 2'b00};

    // Exception return drops back to user mode.
    always_comb begin
        eret_clr_pc       = eret_pc;
        eret_clr_pc[KBIT] = 1'b0;
    end

    // ---------------- next-PC select (priority) ----------------
    always_comb begin
        sel = SEL_SEQ;
        if (irq)              sel = SEL_IRQ;
        else if (exc)         sel = SEL_EXC;
        else if (stall)       sel = SEL_STALL;
        else if (mispredict)  sel = SEL_MISPRED;
        else if (j_valid)     sel = SEL_JUMP;
        else if (eret_valid)  sel = SEL_ERET;
        else if (jr_valid)    sel = SEL_JR;
        else if (pred_taken)  sel = SEL_PRED;
    end

    // ---------------- next-PC mux ----------------
    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_IRQ:     pc_next = IRQ_VEC;
            SEL_EXC:     pc_next = EXC_VEC;
            SEL_STALL:   pc_next = pc;
            SEL_MISPRED: pc_next = br_correct_pc;
            SEL_JUMP:    pc_next = jump_pc;
            SEL_ERET:    pc_next = eret_clr_pc;
            SEL_JR:      pc_next = jr_target;
            SEL_PRED:    pc_next = pred_target;
            default:     pc_next = pc_plus4;
        endcase
    end

    // Reset overrides whatever redirect the inputs would otherwise cause.
    assign redirect = !reset && sel_is_redirect(sel);

    // ---------------- PC register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

    // ---------------- BTB ----------------
    // Training also happens under irq/exc: the branch has left ID either way.
    assign btb_upd_en = br_valid && (sel != SEL_STALL);

    pipeline_btb #(
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (btb_upd_en),
        .upd_pc      (br_pc),
        .upd_taken   (br_taken),
        .upd_target  (br_target)
    );

endmodule

// File: tb/tb_pipeline_if_pcgen.sv
// ---------------------------------------------------------------------------
// tb_pipeline_if_pcgen
//   Directed bench for pipeline_if_pcgen. Two instances share all inputs:
//   dut_a uses the default 16-entry BTB, dut_b a 4-entry BTB so that
//   addresses 0x10 and 0x20 alias to the same slot.
// ---------------------------------------------------------------------------
module tb_pipeline_if_pcgen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic        stall = 1'b0;
    logic        irq = 1'b0;
    logic        exc = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_target = 32'h0;
    logic        br_pred_taken = 1'b0;
    logic [31:0] br_pred_target = 32'h0;
    logic        j_valid = 1'b0;
    logic [25:0] j_index = 26'h0;
    logic        jr_valid = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        eret_valid = 1'b0;
    logic [31:0] eret_pc = 32'h0;

    // ---------------- outputs ----------------
    logic [31:0] a_pc, a_pc_plus4, a_pred_target;
    logic        a_pred_taken, a_redirect;
    logic [31:0] b_pc, b_pc_plus4, b_pred_target;
    logic        b_pred_taken, b_redirect;

    pipeline_if_pcgen #(.BTB_DEPTH(16)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .irq(irq), .exc(exc),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc),
        .br_target(br_target), .br_pred_taken(br_pred_taken),
        .br_pred_target(br_pred_target), .j_valid(j_valid), .j_index(j_index),
        .jr_valid(jr_valid), .jr_target(jr_target), .eret_valid(eret_valid),
        .eret_pc(eret_pc), .pc(a_pc), .pc_plus4(a_pc_plus4),
        .pred_taken(a_pred_taken), .pred_target(a_pred_target),
        .redirect(a_redirect)
    );

    pipeline_if_pcgen #(.BTB_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .irq(irq), .exc(exc),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc),
        .br_target(br_target), .br_pred_taken(br_pred_taken),
        .br_pred_target(br_pred_target), .j_valid(j_valid), .j_index(j_index),
        .jr_valid(jr_valid), .jr_target(jr_target), .eret_valid(eret_valid),
        .eret_pc(eret_pc), .pc(b_pc), .pc_plus4(b_pc_plus4),
        .pred_taken(b_pred_taken), .pred_target(b_pred_target),
        .redirect(b_redirect)
    );

    // ---------------- bookkeeping ----------------
    int n_asserts = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are checked
    // either 1 unit later (combinational) or after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; irq = 1'b0; exc = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; br_pc = 32'h0; br_target = 32'h0;
        br_pred_taken = 1'b0; br_pred_target = 32'h0;
        j_valid = 1'b0; j_index = 26'h0;
        jr_valid = 1'b0; jr_target = 32'h0;
        eret_valid = 1'b0; eret_pc = 32'h0;
    endtask

    task automatic drive_br(input logic taken, input logic [31:0] bpc, input logic [31:0] tgt,
                            input logic ptaken, input logic [31:0] ptgt);
        br_valid = 1'b1; br_taken = taken; br_pc = bpc; br_target = tgt;
        br_pred_taken = ptaken; br_pred_target = ptgt;
    endtask

    // Redirect fetch to addr through a register jump and land there.
    task automatic jr_to(input logic [31:0] addr);
        jr_valid = 1'b1; jr_target = addr;
        step();
        clear_inputs();
        settle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset and idle fetch.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", a_pc, 32'h8000_0000);
        chk("rst_redirect", {31'h0, a_redirect}, 32'h0);
        chk("rst_pred_taken", {31'h0, a_pred_taken}, 32'h0);
        chk("rst_pred_target", a_pred_target, 32'h0);
        reset = 1'b0;
        settle();
        chk("rst_pc_plus4", a_pc_plus4, 32'h8000_0004);
        step(); chk("idle_pc1", a_pc, 32'h8000_0004);
        step(); chk("idle_pc2", a_pc, 32'h8000_0008);
        step(); chk("idle_pc3", a_pc, 32'h8000_000C);
        chk("idle_pred", {31'h0, a_pred_taken}, 32'h0);
        step(); chk("idle_pc4", a_pc, 32'h8000_0010);
        chk("miss_at_10", {31'h0, a_pred_taken}, 32'h0);
        step(); chk("idle_pc5", a_pc, 32'h8000_0014);

        // First resolution of taken branch 0x10 -> 0x40, not predicted.
        drive_br(1'b1, 32'h8000_0010, 32'h8000_0040, 1'b0, 32'h0);
        settle();
        chk("br1_redirect", {31'h0, a_redirect}, 32'h1);
        step(); clear_inputs();
        chk("br1_pc", a_pc, 32'h8000_0040);
        chk("br1_pc_b", b_pc, 32'h8000_0040);

        // Refetch 0x10: now predicted taken (ctr=WT).
        jr_to(32'h8000_0010);
        chk("hit_pred_taken", {31'h0, a_pred_taken}, 32'h1);
        chk("hit_pred_target", a_pred_target, 32'h8000_0040);
        chk("hit_no_redirect", {31'h0, a_redirect}, 32'h0);
        step(); chk("pred_pc", a_pc, 32'h8000_0040);
        // Correct prediction resolves: no redirect, counter WT->ST.
        drive_br(1'b1, 32'h8000_0010, 32'h8000_0040, 1'b1, 32'h8000_0040);
        settle();
        chk("correct_no_redirect", {31'h0, a_redirect}, 32'h0);
        step(); clear_inputs();
        chk("correct_pc", a_pc, 32'h8000_0044);

        // Not taken twice: ST->WT then WT->WNT.
        jr_to(32'h8000_0010);
        chk("nt1_pred", {31'h0, a_pred_taken}, 32'h1);
        step();
        drive_br(1'b0, 32'h8000_0010, 32'h8000_0040, 1'b1, 32'h8000_0040);
        settle();
        chk("nt1_redirect", {31'h0, a_redirect}, 32'h1);
        step(); clear_inputs();
        chk("nt1_pc", a_pc, 32'h8000_0014);
        jr_to(32'h8000_0010);
        chk("nt2_pred", {31'h0, a_pred_taken}, 32'h1);
        step();
        drive_br(1'b0, 32'h8000_0010, 32'h8000_0040, 1'b1, 32'h8000_0040);
        step(); clear_inputs();
        chk("nt2_pc", a_pc, 32'h8000_0014);
        jr_to(32'h8000_0010);
        chk("nt_after_pred", {31'h0, a_pred_taken}, 32'h0);
        chk("nt_after_target", a_pred_target, 32'h8000_0040);
        step(); chk("nt_after_seq", a_pc, 32'h8000_0014);

        // irq beats a simultaneous mispredict.
        irq = 1'b1;
        drive_br(1'b0, 32'h8000_0200, 32'h8000_0300, 1'b1, 32'h8000_0300);
        settle();
        chk("irq_redirect", {31'h0, a_redirect}, 32'h1);
        step(); clear_inputs();
        chk("irq_pc", a_pc, 32'h8000_0004);

        // exc beats stall.
        exc = 1'b1; stall = 1'b1;
        step(); clear_inputs();
        chk("exc_pc", a_pc, 32'h8000_0008);

        // stall beats jump; no redirect and no BTB training.
        stall = 1'b1; j_valid = 1'b1; j_index = 26'h000_0400;
        drive_br(1'b1, 32'h8000_0100, 32'h8000_0200, 1'b0, 32'h0);
        settle();
        chk("stall_redirect", {31'h0, a_redirect}, 32'h0);
        step(); clear_inputs();
        chk("stall_pc", a_pc, 32'h8000_0008);
        jr_to(32'h8000_0100);
        chk("stall_no_train", {31'h0, a_pred_taken}, 32'h0);

        // Jump keeps the region bits of the current pc.
        j_valid = 1'b1; j_index = 26'h000_0400;
        step(); clear_inputs();
        chk("j_pc", a_pc, 32'h8000_1000);

        // eret beats jr and clears the supervisor bit.
        eret_valid = 1'b1; eret_pc = 32'h8000_1234;
        jr_valid = 1'b1; jr_target = 32'h0040_0000;
        settle();
        chk("eret_redirect", {31'h0, a_redirect}, 32'h1);
        step(); clear_inputs();
        chk("eret_pc", a_pc, 32'h0000_1234);
        jr_to(32'h0040_0000);
        chk("jr_pc", a_pc, 32'h0040_0000);

        // Wrap at the top of the address space.
        jr_to(32'hFFFF_FFFC);
        chk("wrap_plus4", a_pc_plus4, 32'h0000_0000);
        step(); chk("wrap_pc", a_pc, 32'h0000_0000);

        // Plain stall hold.
        stall = 1'b1;
        step(); clear_inputs();
        chk("hold_pc", a_pc, 32'h0000_0000);

        // Mid-operation reset with a jr pending.
        jr_valid = 1'b1; jr_target = 32'h0000_5000;
        reset = 1'b1;
        settle();
        chk("midrst_pc_async", a_pc, 32'h8000_0000);
        chk("midrst_redirect", {31'h0, a_redirect}, 32'h0);
        step();
        chk("midrst_pc_held", a_pc, 32'h8000_0000);
        reset = 1'b0;
        clear_inputs();
        jr_to(32'h8000_0010);
        chk("midrst_btb_clear", {31'h0, a_pred_taken}, 32'h0);

        // Aliasing in the 4-entry BTB; also lookup/update on one index.
        drive_br(1'b1, 32'h8000_0010, 32'h8000_0040, 1'b0, 32'h0);
        settle();
        chk("same_idx_old", {31'h0, a_pred_taken}, 32'h0);
        step(); clear_inputs();
        drive_br(1'b1, 32'h8000_0020, 32'h8000_0080, 1'b0, 32'h0);
        step(); clear_inputs();
        chk("alias_pc_b", b_pc, 32'h8000_0080);
        jr_to(32'h8000_0010);
        chk("alias_a_hit", {31'h0, a_pred_taken}, 32'h1);
        chk("alias_b_miss", {31'h0, b_pred_taken}, 32'h0);
        chk("alias_b_target", b_pred_target, 32'h0);
        jr_to(32'h8000_0020);
        chk("alias_b_new", {31'h0, b_pred_taken}, 32'h1);
        chk("alias_b_new_tgt", b_pred_target, 32'h8000_0080);
        step();
        chk("alias_b_pred_pc", b_pc, 32'h8000_0080);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_if_pcgen.md
Name: pipeline_if_pcgen

Overview:
- Parametrised next-generation instruction-fetch PC generator for the 5-stage MIPS pipeline.
- Holds the architectural fetch PC and selects the next PC by fixed priority: reset, interrupt/exception vectors, stall, branch-misprediction correction, jumps, exception return and register jumps.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches are predicted speculatively and resolved in ID.
- Sits before the instruction memory; its prediction outputs travel down the IF/ID register.

Parameters:
- BTB_DEPTH, 16, number of BTB entries; power of two, 2..256. IDX = log2(BTB_DEPTH).
- RESET_VEC, 32'h8000_0000, PC loaded on reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry vector.
- EXC_VEC, 32'h8000_0008, undefined-instruction/exception entry vector.
- KBIT, 31, supervisor bit cleared on exception return.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  load-use hold; PC keeps its value.
- irq  in  1  interrupt request.
- exc  in  1  exception request.
- br_valid  in  1  ID stage holds a resolved conditional branch.
- br_taken  in  1  actual branch outcome.
- br_pc  in  32  address of the resolved branch.
- br_target  in  32  computed branch target (ConBA).
- br_pred_taken  in  1  prediction carried with that branch.
- br_pred_target  in  32  predicted target carried with that branch.
- j_valid  in  1  J/JAL in ID.
- j_index  in  26  jump index field.
- jr_valid  in  1  JR/JALR in ID.
- jr_target  in  32  forwarded rs value.
- eret_valid  in  1  exception return.
- eret_pc  in  32  saved EPC.
- pc  out  32  current fetch PC (register).
- pc_plus4  out  32  pc + 4, combinational.
- pred_taken  out  1  BTB prediction for pc.
- pred_target  out  32  BTB target for pc.
- redirect  out  1  a non-sequential, non-predicted PC was selected this cycle; IF/ID must be flushed.

Behaviour:
- Reset (async):
  - pc = RESET_VEC.
  - All BTB valid bits = 0 and all counters = 2'b01.
  - After reset, pred_taken = 0 and redirect = 0.
- Next-PC priority, registered on the rising edge, highest first:
  1. irq → IRQ_VEC.
  2. exc → EXC_VEC.
  3. stall → pc (hold).
  4. Mispredict → correct PC. Mispredict is br_valid and any of:
     - br_taken != br_pred_taken;
     - br_taken and br_pred_taken and br_target != br_pred_target.
     Correct PC = br_target if br_taken, else br_pc + 4.
  5. j_valid → {pc[31:28], j_index, 2'b00}.
  6. eret_valid → eret_pc with bit KBIT forced to 0.
  7. jr_valid → jr_target.
  8. pred_taken → pred_target.
  9. Otherwise → pc + 4.
- redirect = 1 when any of items 1, 2, 4, 5, 6 or 7 is selected; it is never 1 while stall is selected.
- BTB lookup (combinational on pc):
  - index = pc[IDX+1:2]; tag = pc[31:IDX+2].
  - hit = valid and tag match.
  - pred_taken = hit and ctr[1]; pred_target = stored target (0 when no hit).
- BTB update: on the clock edge when br_valid and !stall, plus the same edge under irq/exc. Updates are suppressed under stall because the branch is re-presented while held.
  - Hit on br_pc: counter increments (saturating at 3) if taken, decrements (saturating at 0) if not; target is written when taken.
  - Miss and taken: allocate the entry (overwrites), tag = br_pc, target = br_target, ctr = 2'b10.
  - Miss and not taken: no change.
- Simultaneous lookup and update on the same index: lookup returns the old contents (write takes effect next cycle).
- All arithmetic is 32-bit modulo; pc + 4 wraps from 32'hFFFF_FFFC to 0.
- Inputs j_valid, jr_valid and eret_valid are mutually exclusive by decode; if violated, the priority above applies.
- Reset asserted mid-operation discards the pending redirect and clears the BTB on the same edge.

Decomposition:
- Shared package: vector constants (RESET_VEC, IRQ_VEC, EXC_VEC), the 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3), and the next-PC select enum.
- One sub-module, pipeline_btb: storage, lookup, update and counter saturation, parametrised by BTB_DEPTH. The top holds the PC register and the priority mux.

Test Plan:
- Reset then 3 idle cycles → pc = 8000_0000, 8000_0004, 8000_0008, 8000_000C; pred_taken = 0.
- Taken branch at 8000_0010 → 8000_0040, resolved with br_pred_taken = 0 → next pc = 8000_0040 and redirect = 1. On the next fetch of 8000_0010, pred_taken = 1 and next pc = 8000_0040 with no redirect.
- Same branch trained to ctr = 3, then resolved not-taken twice → counter reaches 1. First resolution redirects to 8000_0014; afterwards pred_taken = 0.
- irq and a mispredict together → pc = 8000_0004. stall together with j_valid → pc held, redirect = 0, no BTB update.
- eret_valid with eret_pc = 8000_1234 → pc = 0000_1234. jr_valid with 0040_0000 → pc = 0040_0000.
- BTB_DEPTH = 4: branches at 0x10 and 0x20 alias (index 0). The second allocation evicts the first, and a lookup at 0x10 misses.
